hazard_unit: RTL and testbench

Pipeline control block that produces the `ForwardAE`/`ForwardBE` selects consumed by the execute stage's forwarding muxes. It also generates every stall and flush strobe for the five-stage RISC-V core. It keeps its own shadow copy of destination register, register-write and write-source information for the E, M and W stages, advanced in lock-step with the pipeline registers. It also counts stall and flush cycles for performance analysis.

---
 rtl/hazard_unit.sv | 158 +++++++++++++++
 tb/tb_hazard_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Hazard unit for the five-stage RISC-V core: forwarding selects, stall/flush strobes,
// shadow E/M/W destination state and saturating stall/flush event counters.
module hazard_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       rs1D_i,
  input  logic [4:0]       rs2D_i,
  input  logic [4:0]       rdD_i,
  input  logic             RegWriteD_i,
  input  logic [1:0]       WriteSrcD_i,
  input  logic             PCSrcM_i,
  input  logic             DataBusyM_i,
  output logic [1:0]       ForwardAE_o,
  output logic [1:0]       ForwardBE_o,
  output logic             StallF_o,
  output logic             StallD_o,
  output logic             StallE_o,
  output logic             StallM_o,
  output logic             FlushD_o,
  output logic             FlushE_o,
  output logic             FlushM_o,
  output logic             FlushW_o,
  output logic [CNT_W-1:0] StallCount_o,
  output logic [CNT_W-1:0] FlushCount_o
);

  typedef enum logic [2:0] {
    MODE_RESET,
    MODE_BUSY,
    MODE_FLUSH,
    MODE_LOADUSE,
    MODE_NORMAL
  } mode_t;

  localparam logic [1:0] WS_ALU  = 2'b00;
  localparam logic [1:0] WS_LOAD = 2'b01;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [4:0]       r_rs1E, r_rs2E, r_rdE, r_rdM, r_rdW;
  logic             r_RegWriteE, r_RegWriteM, r_RegWriteW;
  logic [1:0]       r_WriteSrcE, r_WriteSrcM;
  logic [CNT_W-1:0] r_stallCnt, r_flushCnt;

  logic             w_lu;
  logic [1:0]       w_fwdA, w_fwdB;
  mode_t            w_mode;

  assign w_lu = r_RegWriteE && (r_WriteSrcE == WS_LOAD) && (r_rdE != 5'd0) &&
                ((r_rdE == rs1D_i) || (r_rdE == rs2D_i));

  // Only ALU results are forwarded from M; loads and links in M are covered by lu / flush.
  always_comb begin
    w_fwdA = 2'b00;
    w_fwdB = 2'b00;
    if (r_RegWriteM && (r_rdM != 5'd0) && (r_rdM == r_rs1E) && (r_WriteSrcM == WS_ALU))
      w_fwdA = 2'b10;
    else if (r_RegWriteW && (r_rdW != 5'd0) && (r_rdW == r_rs1E))
      w_fwdA = 2'b01;
    if (r_RegWriteM && (r_rdM != 5'd0) && (r_rdM == r_rs2E) && (r_WriteSrcM == WS_ALU))
      w_fwdB = 2'b10;
    else if (r_RegWriteW && (r_rdW != 5'd0) && (r_rdW == r_rs2E))
      w_fwdB = 2'b01;
  end

  always_comb begin
    w_mode = MODE_NORMAL;
    if (rst_i)            w_mode = MODE_RESET;
    else if (DataBusyM_i) w_mode = MODE_BUSY;
    else if (PCSrcM_i)    w_mode = MODE_FLUSH;
    else if (w_lu)        w_mode = MODE_LOADUSE;
  end

  always_comb begin
    ForwardAE_o = w_fwdA;
    ForwardBE_o = w_fwdB;
    StallF_o = 1'b0;
    StallD_o = 1'b0;
    StallE_o = 1'b0;
    StallM_o = 1'b0;
    FlushD_o = 1'b0;
    FlushE_o = 1'b0;
    FlushM_o = 1'b0;
    FlushW_o = 1'b0;
    case (w_mode)
      MODE_RESET: begin
        ForwardAE_o = 2'b00;
        ForwardBE_o = 2'b00;
        FlushD_o = 1'b1;
        FlushE_o = 1'b1;
        FlushM_o = 1'b1;
        FlushW_o = 1'b1;
      end
      MODE_BUSY: begin
        StallF_o = 1'b1;
        StallD_o = 1'b1;
        StallE_o = 1'b1;
        StallM_o = 1'b1;
        FlushW_o = 1'b1;
      end
      MODE_FLUSH: begin
        FlushD_o = 1'b1;
        FlushE_o = 1'b1;
        FlushM_o = 1'b1;
      end
      MODE_LOADUSE: begin
        StallF_o = 1'b1;
        StallD_o = 1'b1;
        FlushE_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Shadow state tracks the real pipeline registers, bubbles included.
  always_ff @(posedge clk_i) begin
    case (w_mode)
      MODE_RESET: begin
        r_rs1E <= 5'd0; r_rs2E <= 5'd0; r_rdE <= 5'd0;
        r_RegWriteE <= 1'b0; r_WriteSrcE <= 2'b00;
        r_rdM <= 5'd0; r_RegWriteM <= 1'b0; r_WriteSrcM <= 2'b00;
        r_rdW <= 5'd0; r_RegWriteW <= 1'b0;
        r_stallCnt <= '0;
        r_flushCnt <= '0;
      end
      MODE_BUSY: begin
        r_rdW <= 5'd0; r_RegWriteW <= 1'b0;
        if (r_stallCnt != CNT_MAX) r_stallCnt <= r_stallCnt + CNT_ONE;
      end
      MODE_FLUSH: begin
        r_rs1E <= 5'd0; r_rs2E <= 5'd0; r_rdE <= 5'd0;
        r_RegWriteE <= 1'b0; r_WriteSrcE <= 2'b00;
        r_rdW <= r_rdM; r_RegWriteW <= r_RegWriteM;
        r_rdM <= 5'd0; r_RegWriteM <= 1'b0; r_WriteSrcM <= 2'b00;
        if (r_flushCnt != CNT_MAX) r_flushCnt <= r_flushCnt + CNT_ONE;
      end
      MODE_LOADUSE: begin
        r_rdW <= r_rdM; r_RegWriteW <= r_RegWriteM;
        r_rdM <= r_rdE; r_RegWriteM <= r_RegWriteE; r_WriteSrcM <= r_WriteSrcE;
        r_rs1E <= 5'd0; r_rs2E <= 5'd0; r_rdE <= 5'd0;
        r_RegWriteE <= 1'b0; r_WriteSrcE <= 2'b00;
        if (r_stallCnt != CNT_MAX) r_stallCnt <= r_stallCnt + CNT_ONE;
      end
      default: begin
        r_rdW <= r_rdM; r_RegWriteW <= r_RegWriteM;
        r_rdM <= r_rdE; r_RegWriteM <= r_RegWriteE; r_WriteSrcM <= r_WriteSrcE;
        r_rs1E <= rs1D_i; r_rs2E <= rs2D_i; r_rdE <= rdD_i;
        r_RegWriteE <= RegWriteD_i; r_WriteSrcE <= WriteSrcD_i;
      end
    endcase
  end

  assign StallCount_o = r_stallCnt;
  assign FlushCount_o = r_flushCnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed per-cycle vectors push expectations,
// a negedge monitor pops and compares. Narrow counters expose saturation.
module tb_hazard_unit;

  localparam int TB_CNT_W = 2;

  localparam logic [7:0] S_NONE = 8'b0000_0000;
  localparam logic [7:0] S_RST  = 8'b0000_1111;
  localparam logic [7:0] S_BUSY = 8'b1111_0001;
  localparam logic [7:0] S_BR   = 8'b0000_1110;
  localparam logic [7:0] S_LU   = 8'b1100_0100;

  typedef struct {
    logic [1:0] fa;
    logic [1:0] fb;
    logic [7:0] strb;
    int         sc;
    int         fc;
    int         idx;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [4:0]          rs1D, rs2D, rdD;
  logic                regWriteD;
  logic [1:0]          writeSrcD;
  logic                pcSrcM, dataBusyM;
  logic [1:0]          fwdA, fwdB;
  logic                stallF, stallD, stallE, stallM;
  logic                flushD, flushE, flushM, flushW;
  logic [TB_CNT_W-1:0] stallCount, flushCount;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nFails  = 0;
  int   vecIdx  = 0;

  hazard_unit #(.CNT_W(TB_CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .rs1D_i(rs1D), .rs2D_i(rs2D), .rdD_i(rdD),
    .RegWriteD_i(regWriteD), .WriteSrcD_i(writeSrcD),
    .PCSrcM_i(pcSrcM), .DataBusyM_i(dataBusyM),
    .ForwardAE_o(fwdA), .ForwardBE_o(fwdB),
    .StallF_o(stallF), .StallD_o(stallD), .StallE_o(stallE), .StallM_o(stallM),
    .FlushD_o(flushD), .FlushE_o(flushE), .FlushM_o(flushM), .FlushW_o(flushW),
    .StallCount_o(stallCount), .FlushCount_o(flushCount)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input exp_t e);
    logic [7:0] strb;
    logic [TB_CNT_W-1:0] sc, fc;
    strb = {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW};
    sc = e.sc[TB_CNT_W-1:0];
    fc = e.fc[TB_CNT_W-1:0];
    nChecks++;
    if ({fwdA, fwdB} !== {e.fa, e.fb}) begin
      nFails++;
      $display("[TB] FAIL fwd vec%0d: got A=%b B=%b, want A=%b B=%b", e.idx, fwdA, fwdB, e.fa, e.fb);
    end
    nChecks++;
    if (strb !== e.strb) begin
      nFails++;
      $display("[TB] FAIL strobes vec%0d: got %b, want %b", e.idx, strb, e.strb);
    end
    nChecks++;
    if ({stallCount, flushCount} !== {sc, fc}) begin
      nFails++;
      $display("[TB] FAIL counters vec%0d: got stall=%0d flush=%0d, want stall=%0d flush=%0d",
               e.idx, stallCount, flushCount, sc, fc);
    end
  endtask

  // Drives one cycle of inputs just after the rising edge and queues that cycle's expectation.
  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic rw, input logic [1:0] ws,
                               input logic pc, input logic busy, input logic rs,
                               input logic [1:0] fa, input logic [1:0] fb,
                               input logic [7:0] strb, input int sc, input int fc);
    exp_t e;
    @(posedge clk);
    #1;
    rs1D = rs1; rs2D = rs2; rdD = rd; regWriteD = rw; writeSrcD = ws;
    pcSrcM = pc; dataBusyM = busy; rst = rs;
    e.fa = fa; e.fb = fb; e.strb = strb; e.sc = sc; e.fc = fc; e.idx = vecIdx;
    vecIdx++;
    expQ.push_back(e);
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  initial begin
    int waitCycles;
    rst = 1'b1; rs1D = '0; rs2D = '0; rdD = '0; regWriteD = 1'b0; writeSrcD = 2'b00;
    pcSrcM = 1'b0; dataBusyM = 1'b0;
    repeat (2) @(posedge clk);

    //            rs1 rs2 rd rw ws   pc busy rst  fA fB strobes sc fc
    applyStimulus( 0,  0,  0, 0, 0,  0, 0, 1,    0, 0, S_RST,  0, 0);
    // ALU dependency at distance 1, 2, 3
    applyStimulus( 1,  2,  5, 1, 0,  0, 0, 0,    0, 0, S_NONE, 0, 0);
    applyStimulus( 5,  0, 10, 1, 0,  0, 0, 0,    0, 0, S_NONE, 0, 0);
    applyStimulus( 5,  0, 11, 1, 0,  0, 0, 0,    2, 0, S_NONE, 0, 0);
    applyStimulus( 5,  0, 12, 1, 0,  0, 0, 0,    1, 0, S_NONE, 0, 0);
    applyStimulus( 0,  0,  0, 0, 0,  0, 0, 0,    0, 0, S_NONE, 0, 0);
    // M beats W on the B path when both hold x6
    applyStimulus( 0,  0,  6, 1, 0,  0, 0, 0,    0, 0, S_NONE, 0, 0);
    applyStimulus( 0,  0,  6, 1, 0,  0, 0, 0,    0, 0, S_NONE, 0, 0);
    applyStimulus( 0,  6, 19, 1, 0,  0, 0, 0,    0, 0, S_NONE, 0, 0);
    applyStimulus( 0,  0,  0, 0, 0,  0, 0, 0,    0, 2, S_NONE, 0, 0);
    // lw x7 then add using x7 on rs2
    applyStimulus( 1,  0,  7, 1, 1,  0, 0, 0,    0, 0, S_NONE, 0, 0);
    applyStimulus( 3,  7,  8, 1, 0,  0, 0, 0,    0, 0, S_LU,   0, 0);
    applyStimulus( 3,  7,  8, 1, 0,  0, 0, 0,    0, 0, S_NONE, 1, 0);
    applyStimulus( 0,  0,  0, 0, 0,  0, 0, 0,    0, 1, S_NONE, 1, 0);
    // writes to x0 (ALU and load) then consumers of x0
    applyStimulus( 1,  2,  0, 1, 0,  0, 0, 0,    0, 0, S_NONE, 1, 0);
    applyStimulus( 0,  0,  0, 1, 1,  0, 0, 0,    0, 0, S_NONE, 1, 0);
    applyStimulus( 0,  0, 13, 1, 0,  0, 0, 0,    0, 0, S_NONE, 1, 0);
    applyStimulus( 0,  0,  0, 0, 0,  0, 0, 0,    0, 0, S_NONE, 1, 0);
    // taken branch squashes the x9 writer in E
    applyStimulus( 1,  2,  0, 0, 0,  0, 0, 0,    0, 0, S_NONE, 1, 0);
    applyStimulus( 3,  4,  9, 1, 0,  0, 0, 0,    0, 0, S_NONE, 1, 0);
    applyStimulus( 9,  9, 14, 1, 0,  1, 0, 0,    0, 0, S_BR,   1, 0);
    applyStimulus( 9,  9, 15, 1, 0,  0, 0, 0,    0, 0, S_NONE, 1, 1);
    applyStimulus( 0,  0,  0, 0, 0,  0, 0, 0,    0, 0, S_NONE, 1, 1);
    // reset lands in a load-use stall cycle that would also forward x15 from W
    applyStimulus(15,  0,  7, 1, 1,  0, 0, 0,    0, 0, S_NONE, 1, 1);
    applyStimulus( 7,  0,  8, 1, 0,  0, 0, 1,    0, 0, S_RST,  1, 1);
    applyStimulus( 7,  0,  8, 1, 0,  0, 0, 0,    0, 0, S_NONE, 0, 0);
    applyStimulus( 0,  0,  0, 0, 0,  0, 0, 0,    0, 0, S_NONE, 0, 0);
    // memory busy for 3 cycles with a taken branch held in M
    applyStimulus( 1,  2,  0, 0, 0,  0, 0, 0,    0, 0, S_NONE, 0, 0);
    applyStimulus( 8,  0, 16, 1, 0,  0, 0, 0,    0, 0, S_NONE, 0, 0);
    applyStimulus(16,  0, 17, 1, 0,  1, 1, 0,    0, 0, S_BUSY, 0, 0);
    applyStimulus(16,  0, 17, 1, 0,  1, 1, 0,    0, 0, S_BUSY, 1, 0);
    applyStimulus(16,  0, 17, 1, 0,  1, 1, 0,    0, 0, S_BUSY, 2, 0);
    applyStimulus(16,  0, 17, 1, 0,  1, 0, 0,    0, 0, S_BR,   3, 0);
    applyStimulus(16,  0, 18, 1, 0,  0, 0, 0,    0, 0, S_NONE, 3, 1);
    applyStimulus( 0,  0,  0, 0, 0,  0, 0, 0,    0, 0, S_NONE, 3, 1);
    // stall counter is at its 2-bit maximum: another load-use must not wrap it
    applyStimulus( 0,  0, 20, 1, 1,  0, 0, 0,    0, 0, S_NONE, 3, 1);
    applyStimulus(20,  0, 21, 1, 0,  0, 0, 0,    0, 0, S_LU,   3, 1);
    applyStimulus(20,  0, 21, 1, 0,  0, 0, 0,    0, 0, S_NONE, 3, 1);
    applyStimulus( 0,  0,  0, 0, 0,  0, 0, 0,    1, 0, S_NONE, 3, 1);

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    if (expQ.size() > 0) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
